req_queue_mc: RTL
=================

# req_queue_mc

Multi-channel requestor queue for the chiplet endpoint. Records the source node_id_t of every CRC-validated packet into one of NUM_CH per-class circular queues and exposes counts, sticky error status, peek, per-channel pop and a round-robin arbitrated pop to endpoint software over the bus_protocol_if peripheral port. It sits between the endpoint CRC checker and the endpoint register bus.

## Interface
- NUM_CH, 4: number of channels; 1..8.
- DEPTH, 16: entries per channel; power of two, 2..64.
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- crc_valid  input  1  push strobe, one push per asserted cycle.
- push_ch  input  $clog2(NUM_CH) (min 1)  target channel of the push.
- req  input  node_id_t  requestor ID to enqueue.
- overflow  output  1  single-cycle pulse on a dropped push.
- irq  output  1  interrupt request (see Configuration).
- bus_if  modport peripheral_vital  uses ren, wen, addr, wdata, rdata, error, request_stall.

## Operation
- Address decode: reg = addr[3:2], ch = addr[4 +: CHW], CHW = max(1, $clog2(NUM_CH+1)). ch < NUM_CH selects a channel block; ch == NUM_CH selects the global block; anything else is unmapped.
- Channel block: reg 0 COUNT (RO, 0..DEPTH); reg 1 STATUS (bit0 overflow sticky, bit1 underflow sticky; write 1 clears); reg 2 POP (read returns head, dequeues); reg 3 PEEK (read returns head, no dequeue).
- Global block: reg 0 ARB_POP (read: bit31 valid, bits[30:24] channel, low bits node ID; dequeues winner); reg 1 NONEMPTY (RO, bit i = channel i count != 0); reg 2 IRQ_MASK (RW, NUM_CH bits); reg 3 reserved, reads 0.
- Push: crc_valid with count < DEPTH writes req at tail, tail wraps modulo DEPTH. Push to full channel: data dropped, overflow pulses, STATUS.bit0 of push_ch set.
- Pop or ARB_POP with empty target: rdata 0, no pointer change, STATUS.bit1 set (POP only; ARB_POP with no nonempty channel returns valid=0 and sets nothing).
- Same channel push and pop same cycle: full -> both succeed, no overflow, count unchanged; empty -> pop underflows, push stored, count becomes 1 (no bypass).
- ARB_POP: round-robin starting at channel after last ARB_POP winner; pointer updates only when valid=1. Per-channel POP does not move the arbiter pointer.
- Sticky set and write-1-clear in same cycle: set wins.
- Writes to RO registers or reserved/unmapped addresses: ignored, error=1. Reads of unmapped: rdata 0, error=1.
- request_stall tied 0.

## Timing
- Reset: all queues empty, pointers 0, STATUS 0, IRQ_MASK 0, arbiter pointer 0, rdata 0, error 0, overflow 0, irq 0.
- Read latency 1: rdata/error registered from the ren cycle; pointer/count update at the same edge. rdata returns 0 on cycles with no ren.
- COUNT read in a cycle with a concurrent push/pop returns pre-update value.
- overflow asserted the cycle after the dropped push, one cycle wide.
- ren and wen together: treat as write only.
- Reset mid-operation discards all queued entries.

## Configuration
- REQ_QUEUE_IRQ_EN defined: irq registered = |(NONEMPTY & IRQ_MASK), one-cycle lag behind count changes.
- Not defined: irq tied 0; IRQ_MASK reads 0, writes ignored without error.

## Structure
- chiplet_types_pkg: node_id_t (existing); add req_queue_reg_e (COUNT, STATUS, POP, PEEK) and req_queue_glb_e (ARB_POP, NONEMPTY, IRQ_MASK), plus STATUS bit index constants.
- Sub-module req_queue_chan: one channel's circular buffer (head, tail, count, push/pop/full/empty, head data), instantiated NUM_CH times; top holds decode, sticky status, arbiter, bus registers.

## Test plan
- Push 0x3,0x5 to ch1, read ch1 POP twice -> 0x3 then 0x5; COUNT ch1 reads 2 then 0.
- Fill ch0 with 16 pushes, 17th push -> overflow pulse, ch0 STATUS = 0x1; write 0x1 -> STATUS 0.
- Empty ch2 POP -> rdata 0, STATUS = 0x2; PEEK after one push of 0x7 returns 0x7 twice, COUNT stays 1.
- Push one entry each to ch0,ch2,ch3; three ARB_POP -> channels 0,2,3 with valid=1; fourth -> 0.
- Full ch0: push 0x9 and POP same cycle -> head returned, no overflow, COUNT 16, 0x9 at tail.
- IRQ_EN build: IRQ_MASK=0x2, push to ch1 -> irq 1; pop ch1 -> irq 0; write to COUNT -> error=1.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chiplet_types_pkg
// Description : Shared chiplet endpoint types and the request-queue register map.
// Revision    : 1.0 - initial release
// ============================================================================
package chiplet_types_pkg;

    typedef logic [7:0] node_id_t;

    typedef enum logic [1:0] {
        REG_COUNT  = 2'd0,
        REG_STATUS = 2'd1,
        REG_POP    = 2'd2,
        REG_PEEK   = 2'd3
    } req_queue_reg_e;

    typedef enum logic [1:0] {
        GLB_ARB_POP  = 2'd0,
        GLB_NONEMPTY = 2'd1,
        GLB_IRQ_MASK = 2'd2
    } req_queue_glb_e;

    localparam int c_STATUS_OVF = 0;
    localparam int c_STATUS_UDF = 1;

endpackage
`default_nettype wire

// File: rtl/bus_protocol_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_protocol_if
// Description : Endpoint register bus with master and peripheral views.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_protocol_if;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport master (
        output ren, wen, addr, wdata,
        input  rdata, error, request_stall
    );

    modport peripheral_vital (
        input  ren, wen, addr, wdata,
        output rdata, error, request_stall
    );
endinterface
`default_nettype wire

// File: rtl/req_queue_chan.sv
`default_nettype none
// ============================================================================
// Module      : req_queue_chan
// Description : Single-channel circular buffer of requestor IDs.
// Revision    : 1.0 - initial release
// ============================================================================
module req_queue_chan
    import chiplet_types_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  node_id_t                     i_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output node_id_t                     o_head,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    node_id_t        r_mem [DEPTH];
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the slot the same-cycle push needs, so a full queue still accepts it.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + c_AW'(1);
            if (w_do_pop)  r_head <= r_head + c_AW'(1);
            if (w_do_push & ~w_do_pop)      r_count <= r_count + c_CW'(1);
            else if (w_do_pop & ~w_do_push) r_count <= r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/req_queue_mc.sv
`default_nettype none
// ============================================================================
// Module      : req_queue_mc
// Description : Multi-channel requestor queue with register-bus pop/peek and
//               round-robin arbitrated pop. Define REQ_QUEUE_IRQ_EN for irq.
// Revision    : 1.0 - initial release
// ============================================================================
module req_queue_mc
    import chiplet_types_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           crc_valid,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] push_ch,
    input  node_id_t                                       req,
    output logic                                           overflow,
    output logic                                           irq,
    bus_protocol_if.peripheral_vital                       bus_if
);
    localparam int c_PCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_CHW = $clog2(NUM_CH + 1);
    localparam int c_CW  = $clog2(DEPTH + 1);
    localparam logic [c_CHW-1:0] c_GLB_CH  = c_CHW'(NUM_CH);
    localparam logic [c_PCW-1:0] c_LAST_CH = c_PCW'(NUM_CH - 1);

    logic [1:0]        w_reg;
    logic [c_CHW-1:0]  w_ch;
    logic              w_rd, w_wr, w_is_ch, w_is_glb;
    logic [NUM_CH-1:0] w_sel, w_push, w_pop, w_full, w_empty, w_nonempty;
    logic [NUM_CH-1:0] w_ovf_set, w_udf_set, w_stat_wr, w_arb_onehot, w_irq_mask;
    logic [c_CW-1:0]   w_count [NUM_CH];
    node_id_t          w_head  [NUM_CH];
    logic [NUM_CH-1:0] r_ovf, r_udf;
    logic [c_PCW-1:0]  r_arb_ptr, w_arb_ch;
    node_id_t          w_arb_head;
    logic              w_arb_valid, w_arb_pop;
    logic [31:0]       w_rdata, r_rdata;
    logic              w_err, r_error, r_overflow;
    logic              w_unused;

    assign w_reg     = bus_if.addr[3:2];
    assign w_ch      = bus_if.addr[4 +: c_CHW];
    assign w_wr      = bus_if.wen;
    assign w_rd      = bus_if.ren & ~bus_if.wen;
    assign w_is_ch   = (w_ch < c_GLB_CH);
    assign w_is_glb  = (w_ch == c_GLB_CH);
    assign w_arb_pop = w_rd & w_is_glb & (w_reg == GLB_ARB_POP) & w_arb_valid;
    assign w_unused  = ^{bus_if.addr[1:0], bus_if.addr[31:4+c_CHW], bus_if.wdata};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign w_sel[i]        = (w_ch == c_CHW'(i));
        assign w_push[i]       = crc_valid & (push_ch == c_PCW'(i));
        assign w_arb_onehot[i] = (w_arb_ch == c_PCW'(i));
        assign w_pop[i]        = (w_rd & w_sel[i] & (w_reg == REG_POP)) | (w_arb_pop & w_arb_onehot[i]);
        assign w_ovf_set[i]    = w_push[i] & w_full[i] & ~w_pop[i];
        assign w_udf_set[i]    = w_rd & w_sel[i] & (w_reg == REG_POP) & w_empty[i];
        assign w_stat_wr[i]    = w_wr & w_sel[i] & (w_reg == REG_STATUS);
        assign w_nonempty[i]   = ~w_empty[i];

        req_queue_chan #(.DEPTH(DEPTH)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[i]),
            .i_pop   (w_pop[i]),
            .i_data  (req),
            .o_count (w_count[i]),
            .o_head  (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
    end

    // Round-robin search starting at r_arb_ptr, the channel after the last winner.
    always_comb begin : p_arb
        int idx;
        idx         = 0;
        w_arb_valid = 1'b0;
        w_arb_ch    = '0;
        w_arb_head  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(r_arb_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            for (int j = 0; j < NUM_CH; j++) begin
                if (!w_arb_valid && (j == idx) && w_nonempty[j]) begin
                    w_arb_valid = 1'b1;
                    w_arb_ch    = c_PCW'(j);
                    w_arb_head  = w_head[j];
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_is_ch) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sel[i]) begin
                    case (w_reg)
                        REG_COUNT:  w_rdata = 32'(w_count[i]);
                        REG_STATUS: w_rdata = 32'({r_udf[i], r_ovf[i]});
                        default:    w_rdata = w_empty[i] ? 32'd0 : 32'(w_head[i]);
                    endcase
                end
            end
            w_err = w_wr & (w_reg != REG_STATUS);
        end else if (w_is_glb) begin
            case (w_reg)
                GLB_ARB_POP:  w_rdata = w_arb_valid ? {1'b1, 7'(w_arb_ch), 24'(w_arb_head)} : 32'd0;
                GLB_NONEMPTY: w_rdata = 32'(w_nonempty);
                GLB_IRQ_MASK: w_rdata = 32'(w_irq_mask);
                default:      w_rdata = 32'd0;
            endcase
            w_err = w_wr & (w_reg != GLB_IRQ_MASK);
        end else begin
            w_err = w_wr | w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf      <= '0;
            r_udf      <= '0;
            r_arb_ptr  <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Set terms are OR-ed in last so a same-cycle event beats the clear.
            r_ovf      <= (r_ovf & ~(w_stat_wr & {NUM_CH{bus_if.wdata[c_STATUS_OVF]}})) | w_ovf_set;
            r_udf      <= (r_udf & ~(w_stat_wr & {NUM_CH{bus_if.wdata[c_STATUS_UDF]}})) | w_udf_set;
            r_rdata    <= w_rd ? w_rdata : 32'd0;
            r_error    <= w_err;
            r_overflow <= |w_ovf_set;
            if (w_arb_pop) r_arb_ptr <= (w_arb_ch == c_LAST_CH) ? '0 : w_arb_ch + c_PCW'(1);
        end
    end

`ifdef REQ_QUEUE_IRQ_EN
    logic [NUM_CH-1:0] r_irq_mask;
    logic              r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr & w_is_glb & (w_reg == GLB_IRQ_MASK)) r_irq_mask <= bus_if.wdata[NUM_CH-1:0];
            r_irq <= |(w_nonempty & r_irq_mask);
        end
    end

    assign w_irq_mask = r_irq_mask;
    assign irq        = r_irq;
`else
    assign w_irq_mask = '0;
    assign irq        = 1'b0;
`endif

    assign overflow             = r_overflow;
    assign bus_if.rdata         = r_rdata;
    assign bus_if.error         = r_error;
    assign bus_if.request_stall = 1'b0;

endmodule
`default_nettype wire
